// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: register word indices, address window width and reset values for gpio_bank
package gpio_bank_pkg;
  localparam int WIN_W = 6;
  localparam logic [3:0] REG_OUT     = 4'h0;
  localparam logic [3:0] REG_DIR     = 4'h1;
  localparam logic [3:0] REG_SET     = 4'h2;
  localparam logic [3:0] REG_CLR     = 4'h3;
  localparam logic [3:0] REG_TGL     = 4'h4;
  localparam logic [3:0] REG_IN      = 4'h6;
  localparam logic [3:0] REG_STATUS  = 4'h7;
  localparam logic [3:0] REG_RISE_EN = 4'h8;
  localparam logic [3:0] REG_FALL_EN = 4'h9;
  localparam logic [31:0] RST_VAL    = 32'h0;
  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/gpio_bank_if.sv
// gpio_bank_if: picorv32 native memory bus slice seen by gpio_bank
interface gpio_bank_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master(output mem_valid, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
  modport slave(input mem_valid, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/gpio_bank_sync.sv
// gpio_bank_sync: per-pin input synchroniser; with GPIO_BANK_IRQ_EN also a prev flop for edge detect
module gpio_bank_sync import gpio_bank_pkg::*; #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] s;
  always_ff @(posedge clk or posedge reset)
    if (reset) s <= '0;
    else s <= {s[SYNC_STAGES-2:0], d};
  assign q = s[SYNC_STAGES-1];
`ifdef GPIO_BANK_IRQ_EN
  logic [WIDTH-1:0] prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) prev <= WIDTH'(RST_VAL);
    else prev <= q;
  assign rise = q & ~prev;
  assign fall = ~q & prev;
`else
  assign rise = '0;
  assign fall = '0;
`endif
endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO on the picorv32 native bus; GPIO_BANK_IRQ_EN enables edge-capture irq
module gpio_bank import gpio_bank_pkg::*; #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_F800,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  gpio_bank_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic [WIDTH-1:0] out_r, dir_r, out_n, dir_n, pin_in, rise, fall, wm, wv;
  logic [31:0] rd, rd_irq;
  logic [3:0] idx;
  logic sel, ack, we, unused;
  gpio_bank_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .d(gpio_in), .q(pin_in), .rise(rise), .fall(fall)
  );
  assign sel = bus.mem_valid && bus.mem_addr[31:WIN_W] == BASE_ADDR[31:WIN_W];
  assign ack = sel && !bus.mem_ready;
  assign we  = ack && |bus.mem_wstrb;
  assign idx = bus.mem_addr[WIN_W-1:2];
  assign wm  = WIDTH'(lane_mask(bus.mem_wstrb));
  assign wv  = WIDTH'(bus.mem_wdata & lane_mask(bus.mem_wstrb));
  assign out_n = !we ? out_r :
                 idx == REG_OUT ? (out_r & ~wm) | wv :
                 idx == REG_SET ? out_r | wv :
                 idx == REG_CLR ? out_r & ~wv :
                 idx == REG_TGL ? out_r ^ wv : out_r;
  assign dir_n = we && idx == REG_DIR ? (dir_r & ~wm) | wv : dir_r;
  assign rd = idx == REG_OUT ? 32'(out_r) :
              idx == REG_DIR ? 32'(dir_r) :
              idx == REG_IN  ? 32'(pin_in) : rd_irq;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_r         <= WIDTH'(RST_VAL);
      dir_r         <= WIDTH'(RST_VAL);
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= RST_VAL;
    end else begin
      out_r         <= out_n;
      dir_r         <= dir_n;
      bus.mem_ready <= ack;
      bus.mem_rdata <= ack ? rd : '0;
    end
  assign gpio_out = out_r;
  assign gpio_oe  = dir_r;
`ifdef GPIO_BANK_IRQ_EN
  logic [WIDTH-1:0] st_r, rise_en, fall_en;
  // a fresh edge is OR'd in after the clear so it survives a same-cycle w1c
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_r    <= WIDTH'(RST_VAL);
      rise_en <= WIDTH'(RST_VAL);
      fall_en <= WIDTH'(RST_VAL);
    end else begin
      st_r    <= (st_r & ~(we && idx == REG_STATUS ? wv : '0)) | (rise & rise_en) | (fall & fall_en);
      rise_en <= we && idx == REG_RISE_EN ? (rise_en & ~wm) | wv : rise_en;
      fall_en <= we && idx == REG_FALL_EN ? (fall_en & ~wm) | wv : fall_en;
    end
  assign irq    = |st_r;
  assign rd_irq = idx == REG_STATUS  ? 32'(st_r) :
                  idx == REG_RISE_EN ? 32'(rise_en) :
                  idx == REG_FALL_EN ? 32'(fall_en) : '0;
  assign unused = ^{bus.mem_addr[1:0], bus.mem_wdata, bus.mem_wstrb};
`else
  assign irq    = 1'b0;
  assign rd_irq = '0;
  assign unused = ^{bus.mem_addr[1:0], bus.mem_wdata, bus.mem_wstrb, rise, fall};
`endif
endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised memory-mapped GPIO peripheral on the picorv32 native memory bus, replacing ad-hoc GPIO data/direction decode in the SoC top. Provides WIDTH bidirectional pins with output, direction, atomic set/clear/toggle, synchronised input readback and optional per-pin edge-capture interrupt. Sits beside RAM and the USB UART on the CPU bus; pad-side signals drive SB_IO tristate cells in the top.

## Interface
- WIDTH, 8, number of pins (1..32)
- BASE_ADDR, 32'hFFFF_F800, register window base; 64-byte aligned
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- clk  in  1  system clock (CPU clock)
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  CPU bus request
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_ready  out  1  transfer acknowledge, one-cycle pulse
- mem_rdata  out  32  read data; 0 when not acknowledging (OR-mux friendly)
- gpio_in  in  WIDTH  pad input (asynchronous)
- gpio_out  out  WIDTH  pad output value
- gpio_oe  out  WIDTH  pad output enable, 1 = drive
- irq  out  1  level interrupt, OR of enabled status bits

## Operation
- Select: sel = mem_valid && mem_addr[31:6] == BASE_ADDR[31:6]. Outside window: no ack, rdata 0.
- Register offsets (word): 0x00 OUT rw; 0x04 DIR rw; 0x08 SET wo (1 sets OUT bit); 0x0C CLR wo (1 clears); 0x10 TGL wo (1 inverts); 0x18 IN ro (synchronised pins); 0x1C STATUS rw1c; 0x20 RISE_EN rw; 0x24 FALL_EN rw.
- Unmapped offsets in window and reads of wo registers: acked, read 0, writes ignored.
- Writes honour byte strobes per 8-bit lane; bits >= WIDTH ignored on write, read as 0.
- Input path: gpio_in -> SYNC_STAGES flops -> IN; one further flop holds previous IN. rise = IN & ~prev, fall = ~IN & prev.
- STATUS next = (STATUS & ~w1c_mask) | (rise & RISE_EN) | (fall & FALL_EN); new edge wins over same-cycle clear.
- irq = |STATUS (combinational from registers, glitch-free).
- gpio_out = OUT, gpio_oe = DIR; IN reads the pad even when driven (loopback).

## Timing
- Reset values: OUT, DIR, STATUS, RISE_EN, FALL_EN, sync flops, prev, mem_ready, mem_rdata all 0; irq 0; gpio_oe 0 (all inputs).
- Ack: mem_ready <= sel && !mem_ready; asserted exactly one cycle after first valid cycle, deasserted the next; never two consecutive cycles. Back-to-back transactions: 2 cycles each.
- Register write takes effect on the ack edge; gpio_out/gpio_oe change same edge.
- mem_rdata registered with ack; reflects register state before any same-edge write.
- Pin change before edge k: IN updated at edge k+SYNC_STAGES-1; STATUS bit and irq at edge k+SYNC_STAGES.
- Pulse shorter than one clock may be missed; pins stable from reset high give no edge unless enabled before the first synchronised 0->1 (SYNC_STAGES cycles after reset release).
- Reset mid-transaction: mem_ready drops asynchronously; CPU is reset alongside.

## Configuration
- GPIO_BANK_IRQ_EN defined: edge capture, STATUS/RISE_EN/FALL_EN and irq as above.
- Undefined: prev flop and edge logic removed; offsets 0x1C-0x24 behave as unmapped (read 0, acked); irq tied 0.

## Structure
- Package gpio_bank_pkg: register offset constants, address window width (6), reset values.
- One sub-module gpio_bank_sync: per-pin SYNC_STAGES synchroniser plus prev flop, outputs IN, rise, fall.

## Test plan
- Reset, read all registers -> all 0, gpio_oe 0, irq 0; mem_ready high exactly one cycle per access.
- Write OUT=0xA5, DIR=0x0F, SET=0x10, CLR=0x01, TGL=0xFF -> gpio_out 0x4B, gpio_oe 0x0F; OUT readback 0x4B.
- Write wstrb=4'b0010 data 0xFFFF to OUT (WIDTH=8) -> OUT unchanged; WIDTH=16 build -> OUT[15:8]=0xFF only.
- Drive gpio_in 0x00->0x81 -> IN reads 0x81 after SYNC_STAGES cycles; with RISE_EN=0x01 STATUS=0x01, irq high; write STATUS 0x01 -> irq low.
- Rising edge on enabled pin same cycle as w1c of that bit -> STATUS bit stays 1.
- Access 0xFFFF_F900 and offset 0x14 -> first: no ack, rdata 0; second: acked, reads 0.
